// File: rtl/hack_mem_pkg.sv
// Shared constants for the Hack data-RAM arbiter: bus widths, RAM depth, read-tag bit positions.
package hack_mem_pkg;
    localparam int AW        = 13;
    localparam int DW        = 16;
    localparam int RAM_DEPTH = 8192;

    // Bit positions inside the one-hot read tag.
    localparam int TAG_A = 0;
    localparam int TAG_B = 1;
endpackage

// File: rtl/hack_mem_prio.sv
// Fixed-priority grant (A over B) with a bounded-wait override that forces B after STARVE_LIMIT losses.
// Latency: grant is combinational from req and wait_b; wait_b updates on the clock edge.
// Backpressure: a refused requester simply sees gnt=0 and holds its request.
module hack_mem_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_b;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (b_req && (wait_b == LIMIT)) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Counts consecutive losses of a still-requesting B; any gap in b_req restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_b <= 4'd0;
        end else if (!b_req || b_gnt) begin
            wait_b <= 4'd0;
        end else if (a_gnt && (wait_b < LIMIT)) begin
            wait_b <= wait_b + 4'd1;
        end
    end
endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-port arbiter in front of the single-port 8Kx16 data RAM, returning read data tagged per requester.
// Latency: grant same cycle; read data valid one cycle after the granted read.
// Backpressure: one transaction per cycle; the losing port waits with req held until its gnt.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_load,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out
);
    logic [1:0] rd_tag;

    hack_mem_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .a_req (a_req),
        .b_req (b_req),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        if (a_gnt) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_data    = a_wdata;
        end else if (b_gnt) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_data    = b_wdata;
        end
    end

    // The tag lines up with the RAM's one-cycle registered read; it is live for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag <= 2'b00;
        end else begin
            rd_tag        <= 2'b00;
            rd_tag[TAG_A] <= a_gnt & ~a_we;
            rd_tag[TAG_B] <= b_gnt & ~b_we;
        end
    end

    assign a_rvalid = rd_tag[TAG_A];
    assign b_rvalid = rd_tag[TAG_B];
    assign a_rdata  = ram_out;
    assign b_rdata  = ram_out;
endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural single-port RAM (sync write, registered read).
module tb_hack_mem_arbiter;
    import hack_mem_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          ram_load;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_out;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:RAM_DEPTH-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_data;
        ram_out <= mem[ram_address];
    end

    hack_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_load(ram_load), .ram_address(ram_address), .ram_data(ram_data),
        .ram_out(ram_out)
    );

    // Advance to just after the next rising edge; inputs are changed only at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b0; b_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd3; a_wdata = 16'h0F0F;
        b_req = 1'b1; b_we = 1'b1; b_addr = 13'd4; b_wdata = 16'hF0F0;
        step(); step();
        tests++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_load !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt: a_gnt=%b b_gnt=%b ram_load=%b, required 0 0 0", a_gnt, b_gnt, ram_load);
        end
        tests++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_rvalid: a_rvalid=%b b_rvalid=%b, required 0 0", a_rvalid, b_rvalid);
        end
        rst_n = 1'b1;
        a_we = 1'b0; b_we = 1'b0;
        #1;
        tests++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_gnt: a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
        end
        step();
        idle();
        tests++;
        if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_read: a_rvalid=%b b_rvalid=%b, required 1 0", a_rvalid, b_rvalid);
        end
        step();
    endtask

    task automatic test_port_a();
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd5; a_wdata = 16'h1234;
        #1;
        tests++;
        if (a_gnt !== 1'b1 || ram_load !== 1'b1 || ram_address !== 13'd5 || ram_data !== 16'h1234) begin
            fails++;
            $display("FAIL a_write: gnt=%b load=%b addr=%0d data=%h, required 1 1 5 1234",
                     a_gnt, ram_load, ram_address, ram_data);
        end
        step();
        tests++;
        if (a_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL a_write_no_rvalid: a_rvalid=%b, required 0", a_rvalid);
        end
        a_we = 1'b0;
        #1;
        tests++;
        if (a_gnt !== 1'b1 || ram_load !== 1'b0 || ram_address !== 13'd5) begin
            fails++;
            $display("FAIL a_read_issue: gnt=%b load=%b addr=%0d, required 1 0 5", a_gnt, ram_load, ram_address);
        end
        step();
        idle();
        tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234 || b_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL a_read_data: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 1234 0",
                     a_rvalid, a_rdata, b_rvalid);
        end
        #1;
        tests++;
        if (ram_load !== 1'b0 || ram_address !== 13'd0 || ram_data !== 16'd0) begin
            fails++;
            $display("FAIL idle_mux: load=%b addr=%0d data=%h, required 0 0 0000", ram_load, ram_address, ram_data);
        end
        step();
        tests++;
        if (a_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL a_rvalid_drop: a_rvalid=%b, required 0", a_rvalid);
        end
    endtask

    task automatic test_contention();
        int  b_count = 0;
        logic exp_b, prev_b;
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd2;
        prev_b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_b = (i % 5 == 4);
            #1;
            tests++;
            if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
                fails++;
                $display("FAIL contention_gnt[%0d]: a_gnt=%b b_gnt=%b, required %b %b", i, a_gnt, b_gnt, ~exp_b, exp_b);
            end
            step();
            if (i == 14) idle();
            prev_b = exp_b;
            if (b_rvalid === 1'b1) b_count++;
            tests++;
            if (b_rvalid !== prev_b || a_rvalid !== ~prev_b) begin
                fails++;
                $display("FAIL contention_rvalid[%0d]: a_rvalid=%b b_rvalid=%b, required %b %b",
                         i, a_rvalid, b_rvalid, ~prev_b, prev_b);
            end
        end
        tests++;
        if (b_count != 3) begin
            fails++;
            $display("FAIL contention_b_count: b_rvalid cycles=%0d, required 3", b_count);
        end
        step();
    endtask

    task automatic test_b_drop();
        logic exp_b;
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd2;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) b_req = 1'b0;
            #1;
            tests++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                fails++;
                $display("FAIL b_drop_pre[%0d]: a_gnt=%b b_gnt=%b, required 1 0", i, a_gnt, b_gnt);
            end
            step();
        end
        b_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_b = (i == 4);
            #1;
            tests++;
            if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
                fails++;
                $display("FAIL b_drop_post[%0d]: a_gnt=%b b_gnt=%b, required %b %b", i, a_gnt, b_gnt, ~exp_b, exp_b);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_interleave();
        a_req = 1'b1; a_we = 1'b1; a_addr = 13'd10; a_wdata = 16'hAAAA;
        step();
        idle();
        b_req = 1'b1; b_we = 1'b1; b_addr = 13'd11; b_wdata = 16'hBBBB;
        #1;
        tests++;
        if (b_gnt !== 1'b1 || ram_load !== 1'b1 || ram_address !== 13'd11 || ram_data !== 16'hBBBB) begin
            fails++;
            $display("FAIL b_write: gnt=%b load=%b addr=%0d data=%h, required 1 1 11 bbbb",
                     b_gnt, ram_load, ram_address, ram_data);
        end
        step();
        idle();
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd10;
        step();
        idle();
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd11;
        tests++;
        if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== 16'hAAAA) begin
            fails++;
            $display("FAIL interleave_a: a_rvalid=%b b_rvalid=%b a_rdata=%h, required 1 0 aaaa",
                     a_rvalid, b_rvalid, a_rdata);
        end
        step();
        idle();
        tests++;
        if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || b_rdata !== 16'hBBBB) begin
            fails++;
            $display("FAIL interleave_b: a_rvalid=%b b_rvalid=%b b_rdata=%h, required 0 1 bbbb",
                     a_rvalid, b_rvalid, b_rdata);
        end
        step();
        tests++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL interleave_end: a_rvalid=%b b_rvalid=%b, required 0 0", a_rvalid, b_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic exp_b;
        b_req = 1'b1; b_we = 1'b0; b_addr = 13'd11;
        #1;
        tests++;
        if (b_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midread_gnt: b_gnt=%b, required 1", b_gnt);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (b_gnt !== 1'b0 || ram_load !== 1'b0) begin
            fails++;
            $display("FAIL midread_forced: b_gnt=%b ram_load=%b, required 0 0", b_gnt, ram_load);
        end
        step();
        tests++;
        if (b_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL midread_rvalid: b_rvalid=%b, required 0", b_rvalid);
        end
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 13'd10;
        for (int i = 0; i < 5; i++) begin
            exp_b = (i == 4);
            #1;
            tests++;
            if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin
                fails++;
                $display("FAIL midread_post[%0d]: a_gnt=%b b_gnt=%b, required %b %b", i, a_gnt, b_gnt, ~exp_b, exp_b);
            end
            step();
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_contention();
        test_b_drop();
        test_interleave();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Shares the single-port 8K×16 data RAM (synchronous write, 1-cycle registered read) between two requesters: port A (CPU data access, high priority) and port B (program loader / screen scanner, low priority). Port A wins by default. A bounded-wait counter guarantees that port B is granted after at most STARVE_LIMIT consecutive losses. The block sits between the requesters and the RAM. It drives the RAM's load, address and data inputs, and returns read data tagged to the requester that issued the read.

## Interface
- STARVE_LIMIT, 4: maximum consecutive cycles port B may be refused while requesting; legal range 1–15.
- AW, 13: address width.
- DW, 16: data width.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request. A holds it, together with a_we, a_addr and a_wdata, until granted.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_addr  in  AW  port A word address.
- a_wdata  in  DW  port A write data.
- a_gnt  out  1  port A request accepted in this cycle (combinational).
- a_rvalid  out  1  a_rdata is valid (registered).
- a_rdata  out  DW  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to the port A signals, for port B.
- ram_load  out  1  drives the RAM load input.
- ram_address  out  AW  drives the RAM address input.
- ram_data  out  DW  drives the RAM data input.
- ram_out  in  DW  RAM registered read data.

## Operation
- One transaction per cycle. A transaction completes at the rising edge where gnt=1 and req=1.
- Grant rule, evaluated each cycle:
  - If b_req=1 and wait_b==STARVE_LIMIT, grant B.
  - Otherwise, if a_req=1, grant A.
  - Otherwise, if b_req=1, grant B.
  - Otherwise, no grant.
- At most one gnt is high in any cycle.
- RAM mux:
  - ram_address and ram_data come from the granted port.
  - ram_load = granted port's we.
  - With no grant: ram_load=0, ram_address=0, ram_data=0.
- wait_b counter:
  - Width 4.
  - Increments when b_req=1 and A is granted.
  - Clears when B is granted or when b_req=0.
  - Never exceeds STARVE_LIMIT.
- Read tagging:
  - Register rd_tag (2 bits, one-hot A/B) is set at the edge where a read (we=0) is granted.
  - rd_tag clears to 0 otherwise.
  - a_rvalid = rd_tag[A]; b_rvalid = rd_tag[B].
- a_rdata and b_rdata are both wired to ram_out. They are meaningful only while the matching rvalid is high.
- Writes produce no rvalid.
- A read issued in the cycle after a write to the same address returns the new data, because the RAM writes before it registers the read.

## Timing
- Grant is same-cycle (combinational from req and wait_b). Read latency is 1 cycle: rvalid is high in the cycle after the granted read.
- Back-to-back reads are sustained at 1 per cycle. rvalid may stay high on consecutive cycles and may switch between ports on consecutive cycles.
- Reset (rst_n=0, asynchronous): wait_b=0 and rd_tag=0, so a_rvalid=b_rvalid=0. While rst_n=0, a_gnt, b_gnt and ram_load are forced to 0.
- Reset asserted mid-read: the pending rvalid is dropped and the read is lost. The requester must reissue it.
- Simultaneous a_req and b_req with wait_b<STARVE_LIMIT: A is granted and wait_b increments.
- Requesters must not change addr, we or wdata while req=1 and gnt=0. Dropping req before grant is permitted and clears wait_b if the dropping port is B.

## Structure
- Shared package hack_mem_pkg:
  - constants AW and DW;
  - port-tag encoding TAG_A and TAG_B;
  - RAM depth 8192.
- Sub-module hack_mem_prio is natural. It contains the combinational grant logic plus the wait_b counter. The top level holds the RAM mux and rd_tag.

## Test plan
- Reset: hold rst_n=0 with both req=1 → both gnt=0, ram_load=0, both rvalid=0. Release reset → A is granted in the first cycle.
- Port A only: write 0x1234 to address 5, then read address 5 on the next cycle → a_gnt high on both cycles, ram_load high on the write only, a_rvalid high 1 cycle after the read with a_rdata=0x1234, b_rvalid=0.
- Contention with STARVE_LIMIT=4: both ports read continuously → grants are A,A,A,A,B repeating. b_rvalid is high in exactly 1 of every 5 cycles, and wait_b never exceeds 4.
- B drops its request: b_req high for 2 cycles while A wins, then low 1 cycle, then high again → wait_b restarts from 0, and B's forced grant comes only after 4 further losses.
- Interleaved tags: read A@10 (=0xAAAA) in cycle n and read B@11 (=0xBBBB) in cycle n+1 → a_rvalid in n+1 with 0xAAAA, b_rvalid in n+2 with 0xBBBB, never both high together.
- Reset mid-read: grant a B read, then assert rst_n=0 before the next edge → b_rvalid stays 0 and wait_b reads 0 after release.
